// File: rtl/led_sequencer.sv
// Bus-master LED animator: snoops a 4-byte config window, advances a 16-bit pattern on
// each animation tick and writes it to the LED peripheral as two byte cycles.
// Optional feature macro: LED_SEQ_BOUNCE_EN (builds the bounce mode for MODE 01).
module led_sequencer #(
  parameter logic [7:0]  CFG_BASE = 8'hD0,
  parameter logic [7:0]  LED_BASE = 8'hC0,
  parameter int unsigned PRESCALE = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic       BUS_GNT,
  output logic       BUS_REQ,
  output logic [7:0] M_ADDR,
  output logic [7:0] M_DATA,
  output logic       M_WE
);

  localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, WAIT, REQ, WR_LO, WR_HI} state_t;

  state_t        state, state_nxt;
  logic [3:0]    ctrl;
  logic [7:0]    period;
  logic [15:0]   pattern, pat_nxt;
  logic          dir, dir_nxt;
  logic [PW-1:0] presc;
  logic [7:0]    per_cnt;
  logic          pend;

  logic [7:0] cfg_off;
  logic       cfg_hit, wr_ctrl, wr_per, wr_plo, wr_phi;
  logic       en_now, tick, busy, service;

  assign cfg_off = BUS_ADDR - CFG_BASE;
  assign cfg_hit = BUS_WE && (cfg_off < 8'd4);
  assign wr_ctrl = cfg_hit && (cfg_off == 8'd0);
  assign wr_per  = cfg_hit && (cfg_off == 8'd1);
  assign wr_plo  = cfg_hit && (cfg_off == 8'd2);
  assign wr_phi  = cfg_hit && (cfg_off == 8'd3);

  // The FSM reacts to an in-flight CTRL write so clearing EN drops BUS_REQ on the next edge.
  assign en_now  = wr_ctrl ? BUS_DATA[0] : ctrl[0];
  assign tick    = ctrl[0] && (presc == PRESC_LAST) && (per_cnt == period);
  assign busy    = (state == REQ) || (state == WR_LO) || (state == WR_HI);
  assign service = (state == WAIT) && en_now && (tick || pend);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    pat_nxt = pattern;
    dir_nxt = dir;
    case (ctrl[3:2])
      2'b10: pat_nxt = dir ? pattern - 16'd1 : pattern + 16'd1;
`ifdef LED_SEQ_BOUNCE_EN
      2'b01: begin
        if (!dir) begin
          if (pattern[15]) begin
            dir_nxt = 1'b1;
            pat_nxt = pattern >> 1;
          end else begin
            pat_nxt = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            dir_nxt = 1'b0;
            pat_nxt = pattern << 1;
          end else begin
            pat_nxt = pattern >> 1;
          end
        end
      end
`endif
      default: pat_nxt = dir ? {pattern[0], pattern[15:1]} : {pattern[14:0], pattern[15]};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl    <= '0;
      period  <= '0;
      pattern <= 16'h0001;
      dir     <= 1'b0;
      presc   <= '0;
      per_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      if (!ctrl[0]) begin
        presc   <= '0;
        per_cnt <= '0;
      end else if (presc == PRESC_LAST) begin
        presc   <= '0;
        per_cnt <= (per_cnt == period) ? 8'd0 : per_cnt + 8'd1;
      end else begin
        presc   <= presc + PW'(1);
      end

      if (!en_now || service)  pend <= 1'b0;
      else if (tick && busy)   pend <= 1'b1;

      // Later assignments override the advance: CPU writes win over a coincident tick.
      if (service && !(wr_plo || wr_phi)) begin
        pattern <= pat_nxt;
        dir     <= dir_nxt;
      end
      if (wr_ctrl) begin
        ctrl <= BUS_DATA[3:0];
        dir  <= BUS_DATA[1];
      end
      if (wr_per) period        <= BUS_DATA;
      if (wr_plo) pattern[7:0]  <= BUS_DATA;
      if (wr_phi) pattern[15:8] <= BUS_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en_now) state_nxt = REQ;
      WAIT:  if (!en_now) state_nxt = IDLE;
             else if (tick || pend) state_nxt = REQ;
      REQ:   if (!en_now) state_nxt = IDLE;
             else if (BUS_GNT) state_nxt = WR_LO;
      WR_LO: state_nxt = BUS_GNT ? WR_HI : REQ;
      WR_HI: if (!BUS_GNT) state_nxt = REQ;
             else if (!en_now) state_nxt = IDLE;
             else state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // A lost grant during a data phase suppresses the strobe; the FSM re-requests.
  always_comb begin
    BUS_REQ = busy;
    M_WE    = 1'b0;
    M_ADDR  = 8'h00;
    M_DATA  = 8'h00;
    case (state)
      WR_LO: if (BUS_GNT) begin
        M_WE   = 1'b1;
        M_ADDR = LED_BASE;
        M_DATA = pattern[7:0];
      end
      WR_HI: if (BUS_GNT) begin
        M_WE   = 1'b1;
        M_ADDR = LED_BASE + 8'd1;
        M_DATA = pattern[15:8];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Bus-attached controller that animates the 16-bit LED peripheral without CPU involvement.
- The CPU configures it through a small register window on the shared bus.
- On each animation tick it computes the next pattern, requests the bus from the arbiter and issues two write cycles: low byte to LED_BASE, high byte to LED_BASE+1.

Parameters:
- CFG_BASE, 8'hD0: base address of the 4-byte config window.
- LED_BASE, 8'hC0: address of the LED low-byte register; the high byte is at LED_BASE+1.
- PRESCALE, 100000: CLK cycles per prescaler tick (minimum 1).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- BUS_ADDR  in  8  bus address (snooped for config writes)
- BUS_DATA  in  8  bus write data (snooped)
- BUS_WE  in  1  bus write strobe
- BUS_GNT  in  1  bus grant from arbiter
- BUS_REQ  out  1  bus request to arbiter
- M_ADDR  out  8  master address, valid when M_WE=1
- M_DATA  out  8  master write data
- M_WE  out  1  master write strobe, one cycle per byte

Behaviour:
- Reset state:
  - CTRL=0, PERIOD=0, PATTERN=16'h0001, DIR=0.
  - Prescaler and period counters = 0; state=IDLE.
  - BUS_REQ=0, M_WE=0, M_ADDR=0, M_DATA=0.
- Config writes (BUS_WE=1, address in CFG_BASE..CFG_BASE+3), taking effect next cycle:
  - +0 CTRL: bit0 EN, bit1 DIR_INIT (0=toward bit15), bits3:2 MODE (00 rotate, 01 bounce, 10 count, 11 = rotate).
  - +1 PERIOD.
  - +2 PATTERN[7:0].
  - +3 PATTERN[15:8].
  - Writes to CTRL also load DIR from DIR_INIT.
- Tick generation:
  - Prescaler counts 0..PRESCALE-1 while EN=1 and cleared while EN=0.
  - Period counter advances on prescaler wrap; a tick fires when it reaches PERIOD, and the counter then clears.
  - Tick period = (PERIOD+1)*PRESCALE cycles.
- Next-pattern function, evaluated on tick:
  - rotate: 16-bit rotate by 1 in DIR.
  - bounce: if the edge bit in DIR is set (bit15 for DIR=0, bit0 for DIR=1), toggle DIR and shift the opposite way; otherwise logical shift in DIR.
  - count: +1 (DIR=0) or -1 (DIR=1), modulo 2^16.
- State machine:
  - IDLE: wait for EN=1, then go to REQ so the current PATTERN is written once immediately.
  - WAIT: wait for tick; on tick, PATTERN <= next, then go to REQ. EN=0 returns to IDLE.
  - REQ: BUS_REQ=1; on BUS_GNT=1 go to WR_LO.
  - WR_LO: M_ADDR=LED_BASE, M_DATA=PATTERN[7:0], M_WE=1; go to WR_HI.
  - WR_HI: M_ADDR=LED_BASE+1, M_DATA=PATTERN[15:8], M_WE=1; go to WAIT.
  - BUS_REQ is held from REQ through WR_HI and dropped when entering WAIT.
- Latency: first M_WE occurs 1 cycle after BUS_GNT is sampled high; the two writes are on consecutive cycles.
- Boundary conditions:
  - BUS_GNT low in WR_LO or WR_HI: suppress M_WE that cycle, return to REQ, and re-issue both bytes. The pattern is not re-advanced.
  - Tick while in REQ/WR_LO/WR_HI: pend one tick (single-bit flag; further ticks are dropped); serviced on entry to WAIT.
  - CPU PATTERN write coincident with a tick: the CPU write wins and the tick's advance is discarded.
  - CPU write to CTRL with EN=0 mid-transfer: finish the current WR_HI if already in WR_LO, then go to IDLE. From REQ, drop BUS_REQ immediately.
  - The sequencer never writes its own config window; M_* writes do not update config.
  - RESET mid-transfer: all outputs return to reset values on the next edge.

Optional Feature:
- Macro LED_SEQ_BOUNCE_EN.
- Defined: MODE 01 performs bounce as specified.
- Undefined: bounce logic is not built; MODE 01 behaves as rotate and DIR never self-toggles.

Test Plan:
- PRESCALE=4, write PERIOD=1, PATTERN=16'h0001, then CTRL=8'h01, BUS_GNT tied 1 -> first writes C0=01, C1=00; every 8 cycles C0/C1 show 0002, 0004, ...; wraps 8000 -> 0001.
- CTRL=8'h05 (bounce) with PATTERN=16'h4000, DIR=0 -> successive patterns 8000, 4000, 2000 (DIR toggles at bit15); symmetric at bit0. Without the macro -> 8000, 0001.
- CTRL=8'h0B (count, DIR=1) with PATTERN=16'h0001 -> writes 0000, then FFFF, then FFFE.
- Hold BUS_GNT=0 for 20 cycles after BUS_REQ -> no M_WE, BUS_REQ stays 1. Drop BUS_GNT during WR_HI -> byte pair re-issued in full once GNT returns, same value.
- Clear EN while in REQ -> BUS_REQ=0 next cycle, no M_WE. Clear EN while in WR_LO -> WR_HI still issued, then IDLE.
- Assert RESET during WR_LO -> next cycle M_WE=0, BUS_REQ=0, PATTERN=0001, CTRL=0.
